parity_check_arb: RTL and testbench
===================================

PARITY_CHECK_ARB -- requirements
Module: parity_check_arb

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin grant between requesters; 0 = fixed priority, req0 always wins.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port req0_valid  input  1  requester 0 has a word to check.
REQ-005 Port req0_data  input  31  requester 0 data word.
REQ-006 Port req0_parity  input  1  requester 0 even-parity bit.
REQ-007 Port req0_ready  output  1  requester 0 word accepted this cycle.
REQ-008 Ports req1_valid, req1_data, req1_parity, req1_ready: same as REQ-004..007, for requester 1.
REQ-009 Port res_valid  output  1  result available.
REQ-010 Port res_ready  input  1  consumer accepts the result.
REQ-011 Port res_id  output  1  index of the requester that owns the result.
REQ-012 Port res_count  output  5  number of ones in the accepted 31-bit data word (0..31).
REQ-013 Port res_confirm  output  1  1 when popcount(data) + parity is even.
REQ-014 Port busy  output  1  high in every state other than IDLE.
REQ-015 Port err_cnt  output  8  saturating count of delivered results with res_confirm = 0.

Function
REQ-016 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-017 In IDLE, reqN_ready SHALL be asserted combinationally for the granted requester only, and only when its valid is high; both readies SHALL be 0 in SCAN and DONE.
REQ-018 Grant rule with RR_EN=1: if exactly one requester is valid, grant it; if both are valid, grant the one not granted last; after reset, req0 has priority.
REQ-019 Grant rule with RR_EN=0: req0 SHALL win whenever both requesters are valid.
REQ-020 On the accept edge, the block SHALL capture the data, the parity bit and the requester id, clear the accumulator and slice index, and enter SCAN.
REQ-021 SCAN SHALL process one 3-bit slice per cycle through a single shared 3-bit popcount unit: slice i = data[3i+2:3i] for i = 0..9, and slice 10 = {2'b00, data[30]}; the accumulator SHALL be 5 bits wide and never overflow.
REQ-022 The running parity SHALL be accumulated slice by slice (XOR), with the captured parity bit folded in; res_confirm = ~(XOR of all 31 data bits and the parity bit).
REQ-023 After the edge that processes slice 10 (the 11th edge after the accept edge), the block SHALL enter DONE with res_valid = 1 and res_count, res_confirm and res_id valid.
REQ-024 In DONE, the result outputs SHALL stay stable while res_ready = 0; a cycle with res_valid & res_ready SHALL return the block to IDLE on that edge.
REQ-025 No new request SHALL be accepted in the cycle of result hand-off; the minimum period between accept edges is 13 cycles.
REQ-026 The round-robin pointer SHALL update only on an accept edge.
REQ-027 err_cnt SHALL increment on each result hand-off with res_confirm = 0 and SHALL saturate at 255.
REQ-028 Requester inputs SHALL be ignored outside IDLE; a requester dropping valid before it is granted is not an error.

Reset
REQ-029 When rst_n = 0 at a rising edge, the block SHALL enter IDLE and clear res_valid, res_id, res_count, res_confirm, busy, err_cnt, the accumulator and the slice index to 0, and point round-robin priority to req0.
REQ-030 Reset during SCAN or DONE SHALL abort the operation: no result is delivered and err_cnt is not updated.
REQ-031 Both readies SHALL be 0 during any cycle with rst_n = 0.

Verification
REQ-032 Single request: req0_data=31'h0000_0007, parity=1 -> req0_ready pulses for 1 cycle; res_valid rises 11 edges later with res_count=3, res_confirm=1, res_id=0.
REQ-033 All-ones word: data=31'h7FFF_FFFF, parity=1 -> res_count=31, res_confirm=1; the same word with parity=0 -> res_confirm=0 and err_cnt increments by 1.
REQ-034 Contention, RR_EN=1: both requesters valid continuously -> grants alternate 0,1,0,1; with RR_EN=0 -> req0 is granted every time.
REQ-035 Backpressure: hold res_ready=0 for 20 cycles in DONE -> outputs stay stable, both readies stay 0, busy=1; release -> IDLE on the next edge.
REQ-036 Reset at the 5th SCAN cycle -> next cycle is IDLE, res_valid=0, err_cnt=0, and the next grant goes to req0.
REQ-037 Saturation: deliver 260 results with confirm=0 -> err_cnt=255.

Source files
------------

// File: rtl/parity_check_arb.sv
// Two-requester arbiter that accepts a 31-bit word plus even-parity bit and
// scans it 3 bits per cycle, reporting the popcount and a parity-confirm flag.
module parity_check_arb #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [30:0] req0_data,
  input  logic        req0_parity,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [30:0] req1_data,
  input  logic        req1_parity,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [4:0]  res_count,
  output logic        res_confirm,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [30:0] data_reg;
  logic        par_reg;
  logic [4:0]  acc_reg;
  logic [3:0]  idx_reg;
  logic        prio_reg;
  logic        id_reg;
  logic [4:0]  count_reg;
  logic        confirm_reg;
  logic [7:0]  err_reg;

  logic        grant_id;
  logic        idle_open;
  logic        accept;
  logic [2:0]  slices [0:10];
  logic [2:0]  slice;
  logic [1:0]  slice_pc;
  logic [4:0]  acc_next;
  logic        par_next;
  logic        last_slice;

  // prio_reg names the requester that wins the next tie
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid)
      grant_id = (RR_EN != 0) ? prio_reg : 1'b0;
    else
      grant_id = ~req0_valid;
  end

  assign idle_open  = (state_reg == IDLE) && rst_n;
  assign req0_ready = idle_open & req0_valid & ~grant_id;
  assign req1_ready = idle_open & req1_valid & grant_id;
  assign accept     = req0_ready | req1_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_slice
      assign slices[gi] = data_reg[3*gi +: 3];
    end
  endgenerate
  assign slices[10] = {2'b00, data_reg[30]};

  always_comb begin
    slice = 3'b000;
    if (idx_reg <= 4'd10)
      slice = slices[idx_reg];
  end

  // The single shared popcount unit
  assign slice_pc   = {1'b0, slice[0]} + {1'b0, slice[1]} + {1'b0, slice[2]};
  assign acc_next   = acc_reg + {3'b000, slice_pc};
  assign par_next   = par_reg ^ (^slice);
  assign last_slice = (idx_reg == 4'd10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      par_reg     <= 1'b0;
      acc_reg     <= '0;
      idx_reg     <= '0;
      prio_reg    <= 1'b0;
      id_reg      <= 1'b0;
      count_reg   <= '0;
      confirm_reg <= 1'b0;
      err_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg  <= grant_id ? req1_data : req0_data;
            par_reg   <= grant_id ? req1_parity : req0_parity;
            id_reg    <= grant_id;
            acc_reg   <= '0;
            idx_reg   <= '0;
            prio_reg  <= ~grant_id;
            state_reg <= SCAN;
          end
        end
        SCAN: begin
          acc_reg <= acc_next;
          par_reg <= par_next;
          idx_reg <= idx_reg + 4'd1;
          if (last_slice) begin
            count_reg   <= acc_next;
            confirm_reg <= ~par_next;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_reg <= IDLE;
            if (!confirm_reg && (err_reg != 8'hFF))
              err_reg <= err_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign res_id      = id_reg;
  assign res_count   = count_reg;
  assign res_confirm = confirm_reg;
  assign err_cnt     = err_reg;

endmodule

// File: tb/tb_parity_check_arb.sv
// Directed bench for parity_check_arb: a round-robin instance and a
// fixed-priority instance share the same stimulus.
module tb_parity_check_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_parity, req1_parity;
  logic [30:0] req0_data, req1_data;
  logic        res_ready;

  logic        req0_ready, req1_ready, res_valid, res_id, res_confirm, busy;
  logic [4:0]  res_count;
  logic [7:0]  err_cnt;

  logic        fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id, fp_res_confirm, fp_busy;
  logic [4:0]  fp_res_count;
  logic [7:0]  fp_err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  parity_check_arb #(.RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_parity(req0_parity), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_parity(req1_parity), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count),
    .res_confirm(res_confirm), .busy(busy), .err_cnt(err_cnt)
  );

  parity_check_arb #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_parity(req0_parity), .req0_ready(fp_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_parity(req1_parity), .req1_ready(fp_req1_ready),
    .res_valid(fp_res_valid), .res_ready(res_ready), .res_id(fp_res_id), .res_count(fp_res_count),
    .res_confirm(fp_res_confirm), .busy(fp_busy), .err_cnt(fp_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, check grant, wait for result, optional
  // backpressure hold, hand-off, then check return to IDLE and err_cnt.
  task automatic transact(input logic v0, input logic v1,
                          input logic [30:0] d0, input logic p0,
                          input logic [30:0] d1, input logic p1,
                          input logic exp_id, input logic fp_id,
                          input logic [4:0] exp_cnt, input logic exp_conf,
                          input int hold, input string tag);
    int n;
    logic got;
    logic [4:0] cnt_seen;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_parity = p0;
    req1_valid = v1; req1_data = d1; req1_parity = p1;
    #1;
    check({tag, ".rdy0"}, req0_ready, exp_id == 1'b0);
    check({tag, ".rdy1"}, req1_ready, exp_id == 1'b1);
    check({tag, ".fp_rdy0"}, fp_req0_ready, fp_id == 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, ".busy_scan"}, busy, 1);
    n = 0; got = 1'b0;
    while (n < 20 && !got) begin
      @(posedge clk); @(negedge clk);
      n++;
      got = res_valid;
    end
    check({tag, ".latency"}, n, 11);
    check({tag, ".id"}, res_id, exp_id);
    check({tag, ".fp_id"}, fp_res_id, fp_id);
    check({tag, ".count"}, res_count, exp_cnt);
    check({tag, ".confirm"}, res_confirm, exp_conf);
    cnt_seen = res_count;
    for (int h = 0; h < hold; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      check({tag, ".hold_valid"}, res_valid, 1);
      check({tag, ".hold_count"}, res_count, cnt_seen);
      check({tag, ".hold_rdy"}, {req0_ready, req1_ready}, 0);
      check({tag, ".hold_busy"}, busy, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    if (!exp_conf && exp_err < 255) exp_err++;
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_valid"}, res_valid, 0);
    check({tag, ".err_cnt"}, err_cnt, exp_err);
    $display("txn %s id=%0d count=%0d confirm=%0d err_cnt=%0d", tag, res_id, cnt_seen, exp_conf, err_cnt);
  endtask

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 31'h7; req0_parity = 1'b1;
    req1_valid = 1'b1; req1_data = 31'h0; req1_parity = 1'b0;
    #1;
    check("rst.rdy", {req0_ready, req1_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.rdy_hold", {req0_ready, req1_ready}, 0);
    check("rst.busy", busy, 0);
    check("rst.valid", res_valid, 0);
    check("rst.count", res_count, 0);
    check("rst.confirm", res_confirm, 0);
    check("rst.err", err_cnt, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    transact(1, 0, 31'h0000_0007, 1, 31'h0, 0, 0, 0, 5'd3, 1, 0, "single");
    transact(0, 1, 31'h0, 0, 31'h7FFF_FFFF, 1, 1, 1, 5'd31, 1, 0, "ones_p1");
    transact(1, 0, 31'h7FFF_FFFF, 0, 31'h0, 0, 0, 0, 5'd31, 0, 0, "ones_p0");
    transact(0, 1, 31'h0, 0, 31'h5555_5555, 0, 1, 1, 5'd16, 1, 20, "backpress");

    transact(1, 1, 31'h0000_00FF, 0, 31'h4000_0000, 1, 0, 0, 5'd8, 1, 0, "cont0");
    transact(1, 1, 31'h0000_00FF, 0, 31'h4000_0000, 1, 1, 0, 5'd1, 1, 0, "cont1");
    transact(1, 1, 31'h0000_00FF, 0, 31'h4000_0000, 1, 0, 0, 5'd8, 1, 0, "cont2");
    transact(1, 1, 31'h0000_00FF, 0, 31'h4000_0000, 1, 1, 0, 5'd1, 1, 0, "cont3");

    // Abort in the 5th SCAN cycle after granting req0
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 31'h7; req0_parity = 1'b1;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("abort.busy_before", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    check("abort.busy", busy, 0);
    check("abort.valid", res_valid, 0);
    check("abort.err", err_cnt, 0);
    $display("txn abort busy=%0d res_valid=%0d err_cnt=%0d", busy, res_valid, err_cnt);
    transact(1, 1, 31'h0000_0007, 1, 31'h4000_0000, 1, 0, 0, 5'd3, 1, 0, "after_abort");

    for (int k = 0; k < 260; k++)
      transact(1, 0, 31'h0, 1, 31'h0, 0, 0, 0, 5'd0, 0, 0, "sat");
    check("sat.final", err_cnt, 255);
    check("sat.fp_final", fp_err_cnt, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
